// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM arbiter: a ROM download writer and an image-read renderer.
// Each requester owns one pending slot. The single-port SDRAM is driven by a
// four-state FSM: IDLE -> ISSUE -> SETTLE -> BUSY -> IDLE.
// DL has priority over IMG. IMG is held off while a download is active.
module sdram_arbiter (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        img_req,
  input  logic [24:0] img_addr,
  input  logic [24:0] img_base,
  output logic [7:0]  img_data,
  output logic        img_valid,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_ready,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_BUSY   = 2'd3
  } state_t;

  state_t      state_q;
  logic        dl_act_q;
  logic        dl_pend_q, img_pend_q;
  logic        dl_fly_q, img_fly_q;
  logic [24:0] dl_addr_q;
  logic [7:0]  dl_data_q;
  logic [24:0] img_off_q;
  logic        sd_rd_q, sd_wr_q;
  logic [24:0] sd_addr_q;
  logic [7:0]  sd_din_q;
  logic        img_valid_q;
  logic [7:0]  img_data_q;
  logic        overrun_q;

  logic        dl_rise, dl_cap, img_cap, dl_drop, img_drop;
  logic        grant_dl, grant_img;
  logic        dl_pend_d, img_pend_d;
  logic [24:0] img_sum;

  // Capture/drop decisions, grant selection and slot next-state.
  always_comb begin
    dl_rise    = dl_active & ~dl_act_q;
    dl_cap     = dl_wr & ~dl_pend_q & ~dl_fly_q;
    dl_drop    = dl_wr & (dl_pend_q | dl_fly_q);
    img_cap    = img_req & ~img_pend_q & ~img_fly_q;
    img_drop   = img_req & (img_pend_q | img_fly_q);
    grant_dl   = (state_q == S_IDLE) & sd_ready & dl_pend_q;
    grant_img  = (state_q == S_IDLE) & sd_ready & ~dl_pend_q & img_pend_q & ~dl_active;
    // A download starting silently discards a queued image read.
    dl_pend_d  = dl_cap | (dl_pend_q & ~grant_dl);
    img_pend_d = img_cap | (img_pend_q & ~grant_img & ~dl_rise);
    // Wraps at 25 bits; the carry out is intentionally discarded.
    img_sum    = img_base + img_off_q;
  end

  // Slot payloads: only meaningful while the matching pending flag is set.
  always_ff @(posedge clk_sys) begin
    if (dl_cap) begin
      dl_addr_q <= dl_addr;
      dl_data_q <= dl_data;
    end
    if (img_cap) begin
      img_off_q <= img_addr;
    end
  end

  // Arbitration FSM with registered SDRAM strobes and return path.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dl_act_q    <= 1'b0;
      dl_pend_q   <= 1'b0;
      img_pend_q  <= 1'b0;
      dl_fly_q    <= 1'b0;
      img_fly_q   <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      img_valid_q <= 1'b0;
      img_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      dl_act_q    <= dl_active;
      dl_pend_q   <= dl_pend_d;
      img_pend_q  <= img_pend_d;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      img_valid_q <= 1'b0;
      if (dl_drop | img_drop) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_dl) begin
            state_q   <= S_ISSUE;
            sd_wr_q   <= 1'b1;
            sd_addr_q <= dl_addr_q;
            sd_din_q  <= dl_data_q;
            dl_fly_q  <= 1'b1;
          end else if (grant_img) begin
            state_q   <= S_ISSUE;
            sd_rd_q   <= 1'b1;
            sd_addr_q <= img_sum;
            img_fly_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_SETTLE;
        end
        // sd_ready may still be high from before the strobe; ignore it here.
        S_SETTLE: begin
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (sd_ready) begin
            state_q   <= S_IDLE;
            dl_fly_q  <= 1'b0;
            img_fly_q <= 1'b0;
            if (img_fly_q) begin
              img_valid_q <= 1'b1;
              img_data_q  <= sd_dout;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dl_wait   = dl_pend_q | dl_fly_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign sd_addr   = sd_addr_q;
  assign sd_din    = sd_din_q;
  assign img_valid = img_valid_q;
  assign img_data  = img_data_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a simple SDRAM responder and
// scoreboard queues for expected read addresses, write address/data and
// returned image bytes.
module tb_sdram_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        dl_active, dl_wr, img_req;
  logic [24:0] dl_addr, img_addr, img_base;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic [7:0]  img_data;
  logic        img_valid;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_rd, sd_wr;
  logic [7:0]  sd_dout;
  logic        sd_ready;
  logic        overrun;

  sdram_arbiter dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .img_req   (img_req),
    .img_addr  (img_addr),
    .img_base  (img_base),
    .img_data  (img_data),
    .img_valid (img_valid),
    .sd_addr   (sd_addr),
    .sd_din    (sd_din),
    .sd_rd     (sd_rd),
    .sd_wr     (sd_wr),
    .sd_dout   (sd_dout),
    .sd_ready  (sd_ready),
    .overrun   (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_mis = 0;
  int n_rd = 0, n_wr = 0, n_vld = 0;
  int cyc = 0, t_rd = 0, t_wr = 0;
  int lat = 6;
  int busy_cnt = 0;
  bit pend_rd = 1'b0;
  logic [7:0] model_rdata = 8'h00;

  logic [31:0] exp_rd_addr[$];
  logic [31:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic [31:0] exp_img[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_sys) cyc++;

  // SDRAM responder: busy for lat cycles after a strobe, then ready with data.
  always @(negedge clk_sys) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        sd_ready = 1'b1;
        if (pend_rd) sd_dout = model_rdata;
      end
    end else if (sd_rd || sd_wr) begin
      sd_ready = 1'b0;
      busy_cnt = lat;
      pend_rd  = sd_rd;
    end
  end

  // Output monitor: pops the scoreboard on every strobe and valid pulse.
  always @(negedge clk_sys) begin
    logic [31:0] e, d;
    if (rst_n) begin
      if (sd_rd || sd_wr) chk("rd_wr_exclusive", 32'({sd_rd, sd_wr}) & 32'h3, sd_rd ? 32'h2 : 32'h1);
      if (sd_rd) begin
        n_rd++;
        t_rd = cyc;
        e = (exp_rd_addr.size() != 0) ? exp_rd_addr.pop_front() : 32'hxxxxxxxx;
        chk("rd_addr", 32'(sd_addr), e);
      end
      if (sd_wr) begin
        n_wr++;
        t_wr = cyc;
        e = (exp_wr_addr.size() != 0) ? exp_wr_addr.pop_front() : 32'hxxxxxxxx;
        d = (exp_wr_data.size() != 0) ? exp_wr_data.pop_front() : 32'hxxxxxxxx;
        chk("wr_addr", 32'(sd_addr), e);
        chk("wr_data", 32'(sd_din), d);
      end
      if (img_valid) begin
        n_vld++;
        e = (exp_img.size() != 0) ? exp_img.pop_front() : 32'hxxxxxxxx;
        chk("img_data", 32'(img_data), e);
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_rd_addr.size() != 0 || exp_wr_addr.size() != 0 || exp_img.size() != 0 ||
            !sd_ready || dl_wait) && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < 300), 32'h1);
    repeat (3) tick();
  endtask

  task automatic wait_rd(input int base);
    int k = 0;
    while (n_rd == base && k < 100) begin tick(); k++; end
    chk("wait_rd_timeout", 32'(k < 100), 32'h1);
  endtask

  task automatic wait_wr(input int base);
    int k = 0;
    while (n_wr == base && k < 100) begin tick(); k++; end
    chk("wait_wr_timeout", 32'(k < 100), 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dl_wait"},   32'(dl_wait),   32'h0);
    chk({tag, "_img_valid"}, 32'(img_valid), 32'h0);
    chk({tag, "_sd_rd"},     32'(sd_rd),     32'h0);
    chk({tag, "_sd_wr"},     32'(sd_wr),     32'h0);
    chk({tag, "_overrun"},   32'(overrun),   32'h0);
    chk({tag, "_img_data"},  32'(img_data),  32'h0);
    chk({tag, "_sd_addr"},   32'(sd_addr),   32'h0);
    chk({tag, "_sd_din"},    32'(sd_din),    32'h0);
  endtask

  task automatic img_strobe(input logic [24:0] off);
    img_addr = off;
    img_req  = 1'b1;
    tick();
    img_req  = 1'b0;
  endtask

  initial begin
    int rd0, vld0, wr0;
    rst_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; img_req = 1'b0;
    dl_addr = '0; dl_data = '0; img_addr = '0; img_base = '0;
    sd_ready = 1'b1; sd_dout = 8'h00;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Image read with base offset.
    lat = 6; img_base = 25'h0100000; model_rdata = 8'h5A;
    rd0 = n_rd; vld0 = n_vld;
    exp_rd_addr.push_back(32'h0100123); exp_img.push_back(32'h5A);
    img_strobe(25'h0000123);
    drain("img_read_drain");
    chk("img_read_rd_count", 32'(n_rd - rd0), 32'h1);
    chk("img_read_vld_count", 32'(n_vld - vld0), 32'h1);

    // Download write with dl_wait handshake.
    dl_active = 1'b1; wr0 = n_wr;
    exp_wr_addr.push_back(32'h0000010); exp_wr_data.push_back(32'hC3);
    dl_addr = 25'h0000010; dl_data = 8'hC3; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    chk("dl_wait_rise", 32'(dl_wait), 32'h1);
    wait_wr(wr0);
    tick();
    begin
      int k = 0;
      while (!sd_ready && k < 100) begin tick(); k++; end
      chk("dl_ready_timeout", 32'(k < 100), 32'h1);
    end
    chk("dl_wait_busy", 32'(dl_wait), 32'h1);
    tick();
    chk("dl_wait_fall", 32'(dl_wait), 32'h0);
    drain("dl_write_drain");
    dl_active = 1'b0;
    tick();

    // Simultaneous strobes: write first, then read.
    img_base = 25'h0; model_rdata = 8'h3C; vld0 = n_vld;
    exp_wr_addr.push_back(32'h0000020); exp_wr_data.push_back(32'h77);
    exp_rd_addr.push_back(32'h0000055); exp_img.push_back(32'h3C);
    dl_addr = 25'h0000020; dl_data = 8'h77; img_addr = 25'h0000055;
    dl_wr = 1'b1; img_req = 1'b1;
    tick();
    dl_wr = 1'b0; img_req = 1'b0;
    drain("simul_drain");
    chk("simul_dl_first", 32'(t_wr < t_rd), 32'h1);
    chk("simul_rd_after_busy", 32'(t_rd > t_wr + lat), 32'h1);
    chk("simul_one_valid", 32'(n_vld - vld0), 32'h1);

    // Download start discards a queued image read.
    rd0 = n_rd; vld0 = n_vld; wr0 = n_wr;
    exp_wr_addr.push_back(32'h0000030); exp_wr_data.push_back(32'h11);
    dl_addr = 25'h0000030; dl_data = 8'h11; img_addr = 25'h0000040;
    dl_wr = 1'b1; img_req = 1'b1;
    tick();
    dl_wr = 1'b0; img_req = 1'b0;
    wait_wr(wr0);
    tick();
    dl_active = 1'b1;
    drain("discard_drain");
    dl_active = 1'b0;
    repeat (12) tick();
    chk("discard_no_rd", 32'(n_rd - rd0), 32'h0);
    chk("discard_no_vld", 32'(n_vld - vld0), 32'h0);
    chk("discard_no_overrun", 32'(overrun), 32'h0);

    // A read already in flight still completes across a download start.
    model_rdata = 8'hE1; rd0 = n_rd; vld0 = n_vld;
    exp_rd_addr.push_back(32'h0000060); exp_img.push_back(32'hE1);
    img_strobe(25'h0000060);
    wait_rd(rd0);
    tick();
    dl_active = 1'b1;
    drain("inflight_drain");
    dl_active = 1'b0;
    chk("inflight_vld", 32'(n_vld - vld0), 32'h1);

    // Second strobe while the first read is busy is dropped.
    model_rdata = 8'h42; rd0 = n_rd; vld0 = n_vld;
    exp_rd_addr.push_back(32'h0000070); exp_img.push_back(32'h42);
    img_strobe(25'h0000070);
    wait_rd(rd0);
    repeat (3) tick();
    img_strobe(25'h0000071);
    chk("overrun_set", 32'(overrun), 32'h1);
    drain("overrun_drain");
    chk("overrun_one_rd", 32'(n_rd - rd0), 32'h1);
    chk("overrun_one_vld", 32'(n_vld - vld0), 32'h1);
    chk("overrun_sticky", 32'(overrun), 32'h1);

    // Address wrap at 25 bits.
    img_base = 25'h1FFFFF0; model_rdata = 8'h99;
    exp_rd_addr.push_back(32'h0000010); exp_img.push_back(32'h99);
    img_strobe(25'h0000020);
    drain("wrap_drain");

    // Reset during BUSY aborts the read.
    lat = 8; img_base = 25'h0; model_rdata = 8'hBB; rd0 = n_rd; vld0 = n_vld;
    exp_rd_addr.push_back(32'h0000080);
    img_strobe(25'h0000080);
    wait_rd(rd0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midreset_no_vld", 32'(n_vld - vld0), 32'h0);
    chk("midreset_no_rd", 32'(n_rd - rd0), 32'h1);
    model_rdata = 8'h6D; vld0 = n_vld;
    exp_rd_addr.push_back(32'h0000090); exp_img.push_back(32'h6D);
    img_strobe(25'h0000090);
    drain("post_reset_drain");
    chk("post_reset_vld", 32'(n_vld - vld0), 32'h1);

    chk("rd_queue_empty", 32'(exp_rd_addr.size()), 32'h0);
    chk("img_queue_empty", 32'(exp_img.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 rst_n  in  1  reset; asynchronous, active-low.
REQ-003 dl_active  in  1  ROM download in progress (level).
REQ-004 dl_wr  in  1  download write strobe, one cycle.
REQ-005 dl_addr  in  25  download byte address.
REQ-006 dl_data  in  8  download byte.
REQ-007 dl_wait  out  1  download write pending or in flight; the source holds further strobes while high.
REQ-008 img_req  in  1  renderer image-read strobe, one cycle.
REQ-009 img_addr  in  25  image byte offset.
REQ-010 img_base  in  25  image region base address, static outside download.
REQ-011 img_data  out  8  returned image byte.
REQ-012 img_valid  out  1  img_data valid, one-cycle pulse.
REQ-013 sd_addr  out  25  SDRAM byte address.
REQ-014 sd_din  out  8  SDRAM write data.
REQ-015 sd_rd  out  1  SDRAM read strobe, one cycle.
REQ-016 sd_wr  out  1  SDRAM write strobe, one cycle.
REQ-017 sd_dout  in  8  SDRAM read data, valid while sd_ready=1 after a read.
REQ-018 sd_ready  in  1  SDRAM idle/complete; drops within one cycle of a strobe and rises on completion.
REQ-019 overrun  out  1  sticky flag: a request was dropped.

Function
REQ-020 The block shall hold one pending slot per requester: DL (addr, data) and IMG (offset).
REQ-021 The DL slot shall be captured when dl_wr=1 and the slot is empty and no DL access is in flight; dl_wait shall rise in the next cycle.
REQ-022 The IMG slot shall be captured when img_req=1 and the slot is empty and no IMG access is in flight.
REQ-023 A strobe that arrives while its slot is occupied or its access is in flight shall be dropped and shall set overrun, which is cleared only by reset.
REQ-024 The FSM shall have four states: IDLE, ISSUE, SETTLE and BUSY.
REQ-025 IDLE -> ISSUE when sd_ready=1 and either slot is pending.
 - DL has priority over IMG.
 - IMG is eligible only when dl_active=0.
REQ-026 ISSUE lasts exactly one cycle.
 - Asserts sd_wr (DL) or sd_rd (IMG).
 - sd_addr = dl_addr, or (img_base + img_addr) modulo 2^25; sd_din = dl_data.
 - The granted slot is freed.
REQ-027 SETTLE lasts one cycle with sd_ready ignored, then the FSM goes to BUSY.
REQ-028 BUSY -> IDLE on the first cycle with sd_ready=1.
 - For a read: img_data <= sd_dout and img_valid pulses in that same cycle.
 - For a write: dl_wait falls in that cycle unless the DL slot has been refilled.
REQ-029 sd_addr and sd_din shall hold their values from ISSUE until the next ISSUE.
REQ-030 On a dl_active rising edge, a pending IMG slot shall be discarded without a strobe and without a valid pulse, and overrun shall not be set.
 - An IMG read already in flight completes normally and delivers its img_valid.
REQ-031 When dl_wr and img_req arrive in the same cycle, both shall be captured; DL is issued first.
REQ-032 Minimum access latency from strobe to completion shall be 4 cycles plus the SDRAM busy time: capture, ISSUE, SETTLE, BUSY.
REQ-033 Address addition shall wrap at 25 bits with no carry out.
REQ-034 The block shall never assert sd_rd and sd_wr together, and never strobe outside ISSUE.

Reset
REQ-035 While rst_n=0, the block shall go to state IDLE with both slots empty.
 - Outputs: dl_wait=0, img_valid=0, sd_rd=0, sd_wr=0, overrun=0, img_data=0, sd_addr=0, sd_din=0.
REQ-036 A reset asserted mid-access shall abort it with no further strobes and no img_valid pulse.
 - After release, the FSM starts in IDLE and waits for sd_ready=1 before any issue.

Verification
REQ-037 Image read: dl_active=0, img_base=0x100000, img_addr=0x00123; SDRAM model returns 0x5A after 6 cycles.
 - Expect sd_rd one cycle with sd_addr=0x100123.
 - Expect img_valid one cycle with img_data=0x5A.
REQ-038 Download write: dl_active=1, dl_wr with addr 0x0000010, data 0xC3.
 - Expect dl_wait=1 the next cycle and sd_wr with sd_addr=0x0000010, sd_din=0xC3.
 - Expect dl_wait=0 on the completion cycle.
REQ-039 Simultaneous strobes: dl_wr and img_req in the same cycle with dl_active=0.
 - Expect sd_wr issued first, then sd_rd after sd_ready returns; exactly one img_valid.
REQ-040 Overrun: a second img_req while the first read is in BUSY.
 - Expect overrun=1, exactly one sd_rd and one img_valid.
REQ-041 Wrap: img_base=0x1FFFFF0, img_addr=0x20 -> expect sd_addr=0x0000010.
REQ-042 Reset mid-read: rst_n=0 during BUSY, then released.
 - Expect no img_valid, all outputs at reset values, and the next img_req served normally.
